// File: rtl/score_bcd_driver.sv
// score_bcd_driver: sequential binary-to-BCD converter for the blackjack score
// display. Converts a saturated 6-bit score with a shift-add-3 engine and
// drives the dual 7-segment decoder's digit and blanking inputs.
module score_bcd_driver #(
  parameter int unsigned BLINK_DIV = 8,
  parameter int unsigned MAX_SCORE = 39
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [5:0] BIN,
  input  logic       BLANK,
  input  logic       BLINK,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVR,
  output logic [1:0] DIGIT_H,
  output logic [3:0] DIGIT_L,
  output logic       OFF
);

  localparam logic [0:0]  IDLE    = 1'b0;
  localparam logic [0:0]  SHIFT   = 1'b1;
  localparam logic [2:0]  N_SHIFT = 3'd6;
  localparam logic [5:0]  MAX6    = 6'(MAX_SCORE);
  localparam logic [15:0] DIV_M1  = 16'(BLINK_DIV - 1);

  logic [0:0]  state;
  logic [5:0]  sh;
  logic [3:0]  tens;
  logic [3:0]  units;
  logic [2:0]  cnt;
  logic [15:0] blink_cnt;
  logic        phase;

  logic [3:0]  tens_adj;
  logic [3:0]  units_adj;
  logic [3:0]  tens_nx;
  logic [3:0]  units_nx;
  logic [5:0]  sh_nx;
  logic [5:0]  bin_sat;

  // One double-dabble step: add-3 correction on each nibble, then shift left.
  always_comb begin
    tens_adj  = (tens  >= 4'd5) ? tens  + 4'd3 : tens;
    units_adj = (units >= 4'd5) ? units + 4'd3 : units;
    {tens_nx, units_nx, sh_nx} = {tens_adj, units_adj, sh} << 1;
    bin_sat   = (BIN > MAX6) ? MAX6 : BIN;
  end

  // Conversion FSM; output digits only update on the final shift.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      sh      <= '0;
      tens    <= '0;
      units   <= '0;
      cnt     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      OVR     <= 1'b0;
      DIGIT_H <= '0;
      DIGIT_L <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            sh    <= bin_sat;
            tens  <= '0;
            units <= '0;
            cnt   <= N_SHIFT;
            BUSY  <= 1'b1;
            OVR   <= (BIN > MAX6);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sh    <= sh_nx;
          tens  <= tens_nx;
          units <= units_nx;
          cnt   <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            DIGIT_H <= tens_nx[1:0];
            DIGIT_L <= units_nx;
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Blink timebase: free-running only while BLINK is high.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!BLINK) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == DIV_M1) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 16'd1;
    end
  end

  // Registered display blank; BLANK overrides the blink phase.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) OFF <= 1'b1;
    else      OFF <= BLANK | (BLINK & phase);
  end

endmodule

// File: doc/score_bcd_driver.md
Name: score_bcd_driver

Overview:
- Sequential binary-to-BCD converter with display-blanking control for the blackjack score display.
- Sits directly upstream of the dual 7-segment decoder.
- Takes a 6-bit binary hand score on a START pulse and converts it with an iterative shift-add-3 (double-dabble) engine.
- Drives the decoder's DIGIT_H[1:0], DIGIT_L[3:0] and OFF inputs, including blank and blink modes.

Parameters:
- BLINK_DIV, 8, blink half-period in CLK cycles; legal range 2..65535.
- MAX_SCORE, 39, saturation ceiling; the largest value representable with a 2-bit tens digit.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle request to convert BIN; sampled only in IDLE.
- BIN  input  6  binary score, 0..63.
- BLANK  input  1  level; forces OFF=1 while high.
- BLINK  input  1  level; display flashes at the BLINK_DIV rate while high.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when new digits are presented.
- OVR  output  1  high if the last converted BIN exceeded MAX_SCORE.
- DIGIT_H  output  2  tens digit, 0..3, registered.
- DIGIT_L  output  4  units digit, 0..9 BCD, registered.
- OFF  output  1  display blank, registered; 1 = segments off.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, BUSY=0, DONE=0, OVR=0, DIGIT_H=0, DIGIT_L=0, OFF=1, blink counter=0, blink phase=0. Release takes effect at the first rising edge with RST=1.
- FSM has two states: IDLE and SHIFT.
- IDLE with START=1 at a rising edge (edge 0):
  - Load the shift register with sat(BIN) = min(BIN, MAX_SCORE).
  - Clear the internal tens and units nibbles (4 bits each).
  - Set the iteration counter to 6, BUSY=1, and go to SHIFT.
  - OVR is latched at this edge: 1 if BIN > MAX_SCORE, else 0.
- SHIFT, each edge:
  - Each BCD nibble >= 5 first gets +3.
  - Then the {tens, units, shift register} concatenation shifts left by 1.
  - The counter decrements.
- Edge 6, the 6th shift:
  - DIGIT_H <= tens[1:0] and DIGIT_L <= units, both using the post-shift values.
  - DONE=1 for exactly one cycle, BUSY=0, state=IDLE.
- Latency: DONE is high in the cycle after edge 6, and the digits are valid from that same cycle. BUSY is high for exactly 6 cycles.
- DIGIT_H/DIGIT_L hold their previous values throughout a conversion and never show intermediate values.
- START while BUSY=1 is ignored: no queueing and no restart.
- START in the cycle where DONE=1 is accepted, since the state is already IDLE. Back-to-back throughput is one conversion per 7 cycles.
- After saturation, tens is always <= 3, so bits [3:2] of the tens nibble are always 0 on output.
- Blink counter:
  - Free-running while BLINK=1. Counts 0..BLINK_DIV-1, then wraps to 0 and toggles the phase.
  - BLINK=0 forces counter=0 and phase=0 synchronously.
- OFF is registered: OFF <= BLANK | (BLINK & phase). It reflects input changes one cycle later.
- BLANK has priority over blink. It does not stop a conversion; digits still update under BLANK.
- Reset asserted mid-conversion aborts immediately to the reset values. No DONE is issued for the aborted request.

Test Plan:
- Reset, then release RST. Require OFF=1, digits 0/0, BUSY=0, DONE=0. Hold BLANK=0, BLINK=0: OFF=0 one cycle after release.
- START with BIN=21. Require BUSY=1 for 6 cycles, then DONE pulse with DIGIT_H=2, DIGIT_L=1, OVR=0. Digits read 0/0 during BUSY.
- Sweep BIN=0..39, one conversion each. Require DIGIT_H*10+DIGIT_L == BIN every time. Then BIN=45 and BIN=63: require 3/9 with OVR=1.
- START with BIN=17, then pulse START with BIN=30 at cycle 3 of BUSY. Require a single DONE with 1/7. Then START with BIN=30 in the DONE cycle: require the next DONE 7 cycles later with 3/0.
- BLINK_DIV=8, BLINK=1. Require OFF toggling every 8 cycles: low 8, high 8. Assert BLANK mid-phase: OFF=1 next cycle. Drop BLINK: OFF=0 next cycle, phase restarts at 0.
- Assert RST at cycle 4 of a conversion of BIN=25. Require immediate reset values, no DONE. After release, START with BIN=25 yields 2/5.
